// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order imem requests under a
// credit limit, and presents returned words in order to the IF/ID register.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirectIN,
   input  logic [31:0] redirectPcIN,
   output logic        imemReqValid,
   output logic [31:0] imemReqAddr,
   input  logic        imemReqReady,
   input  logic        imemRespValid,
   input  logic [31:0] imemRespData,
   input  logic        readyIN,
   output logic        validOUT,
   output logic [31:0] instructionOUT,
   output logic [31:0] pcOUT,
   output logic [31:0] pcPlus4OUT
);
   localparam int AW = $clog2(BUF_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0] DEPTH_U = (CW+1)'(BUF_DEPTH);

   logic [31:0]   r_fetch_pc;
   logic [31:0]   r_pc     [BUF_DEPTH];
   logic [31:0]   r_pc4    [BUF_DEPTH];
   logic [31:0]   r_instr  [BUF_DEPTH];
   logic          r_filled [BUF_DEPTH];
   logic [AW-1:0] r_head, r_tail, r_fill;
   logic [CW-1:0] r_occ, r_unfilled, r_drop;

   logic [CW:0]   w_used;
   logic [CW-1:0] w_outstanding;
   logic [CW-1:0] w_drop_redirect;
   logic          w_req_fire, w_fill, w_drop_resp, w_deq;

   // Credits cover both live entries and stale responses still in flight, so
   // responses never need back-pressure.
   assign w_used       = {1'b0, r_occ} + {1'b0, r_drop};
   assign imemReqValid = reset && !redirectIN && (w_used < DEPTH_U);
   assign imemReqAddr  = r_fetch_pc;
   assign w_req_fire   = imemReqValid && imemReqReady;

   assign w_drop_resp  = imemRespValid && !redirectIN && (r_drop != '0);
   assign w_fill       = imemRespValid && !redirectIN && (r_drop == '0) && (r_unfilled != '0);

   assign validOUT       = r_filled[r_head] && !redirectIN;
   assign instructionOUT = r_instr[r_head];
   assign pcOUT          = r_pc[r_head];
   assign pcPlus4OUT     = r_pc4[r_head];
   assign w_deq          = validOUT && readyIN;

   // Every request still owed a response becomes stale on redirect; one arriving now is consumed.
   assign w_outstanding   = r_drop + r_unfilled;
   assign w_drop_redirect = w_outstanding - CW'(imemRespValid && (w_outstanding != '0));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_fetch_pc <= RESET_PC;
         r_head     <= '0;
         r_tail     <= '0;
         r_fill     <= '0;
         r_occ      <= '0;
         r_unfilled <= '0;
         r_drop     <= '0;
      end else if (redirectIN) begin
         r_fetch_pc <= {redirectPcIN[31:2], 2'b00};
         r_head     <= '0;
         r_tail     <= '0;
         r_fill     <= '0;
         r_occ      <= '0;
         r_unfilled <= '0;
         r_drop     <= w_drop_redirect;
      end else begin
         if (w_req_fire) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
            r_tail     <= r_tail + 1'b1;
         end
         if (w_fill) r_fill <= r_fill + 1'b1;
         if (w_deq)  r_head <= r_head + 1'b1;
         r_occ      <= r_occ + CW'(w_req_fire) - CW'(w_deq);
         r_unfilled <= r_unfilled + CW'(w_req_fire) - CW'(w_fill);
         r_drop     <= r_drop - CW'(w_drop_resp);
      end
   end

   // Allocate, fill and dequeue always target distinct entries, so their order here is irrelevant.
   for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            r_pc[gi]     <= '0;
            r_pc4[gi]    <= '0;
            r_instr[gi]  <= '0;
            r_filled[gi] <= 1'b0;
         end else if (redirectIN) begin
            r_filled[gi] <= 1'b0;
         end else begin
            if (w_req_fire && (r_tail == AW'(gi))) begin
               r_pc[gi]     <= r_fetch_pc;
               r_pc4[gi]    <= r_fetch_pc + 32'd4;
               r_filled[gi] <= 1'b0;
            end
            if (w_fill && (r_fill == AW'(gi))) begin
               r_instr[gi]  <= imemRespData;
               r_filled[gi] <= 1'b1;
            end
            if (w_deq && (r_head == AW'(gi))) r_filled[gi] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset && imemRespValid && !redirectIN)
         assert (w_outstanding != '0);
   end
endmodule

// File: tb/tb_fetch_stage.sv
// Randomized and directed bench for fetch_stage: an in-order memory model plus a
// sequential-PC reference for the fetch address and the presented instruction stream.
module tb_fetch_stage;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        redirectIN = 1'b0;
   logic [31:0] redirectPcIN = '0;
   logic        imemReqReady = 1'b0;
   logic        imemRespValid = 1'b0;
   logic [31:0] imemRespData = '0;
   logic        readyIN = 1'b0;
   logic        imemReqValid, validOUT;
   logic [31:0] imemReqAddr, instructionOUT, pcOUT, pcPlus4OUT;
   logic        w2_reqValid, w2_validOUT;
   logic [31:0] w2_reqAddr, w2_instr, w2_pc, w2_pc4;

   fetch_stage #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .redirectIN(redirectIN), .redirectPcIN(redirectPcIN),
      .imemReqValid(imemReqValid), .imemReqAddr(imemReqAddr), .imemReqReady(imemReqReady),
      .imemRespValid(imemRespValid), .imemRespData(imemRespData), .readyIN(readyIN),
      .validOUT(validOUT), .instructionOUT(instructionOUT), .pcOUT(pcOUT), .pcPlus4OUT(pcPlus4OUT));

   // Shares every input with dut; its request timing is identical, only its PCs are offset.
   fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(4)) dut_wrap (
      .clk(clk), .reset(reset), .redirectIN(redirectIN), .redirectPcIN(redirectPcIN),
      .imemReqValid(w2_reqValid), .imemReqAddr(w2_reqAddr), .imemReqReady(imemReqReady),
      .imemRespValid(imemRespValid), .imemRespData(imemRespData), .readyIN(readyIN),
      .validOUT(w2_validOUT), .instructionOUT(w2_instr), .pcOUT(w2_pc), .pcPlus4OUT(w2_pc4));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int mem_mode = 0;          // 0: reply next cycle, 1: hold replies, 2: random delay
   logic [31:0] q_addr[$];
   logic [31:0] d2_pc[$];
   logic [31:0] d2_pc4[$];
   logic [31:0] exp_fetch, exp_out;
   int deq_count = 0;
   logic        s_valid, s_reqvalid, s_req, s_deq, s_resp;
   logic [31:0] s_pc, s_pc4, s_reqaddr;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      redirectIN = 1'b0;
      imemRespValid = 1'b0;
      readyIN = 1'b0;
      imemReqReady = 1'b0;
      q_addr.delete();
      d2_pc.delete();
      d2_pc4.delete();
      exp_fetch = 32'h0;
      exp_out = 32'h0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic step(input logic rdy, input logic redir, input logic [31:0] tgt, input logic req_rdy);
      readyIN = rdy;
      redirectIN = redir;
      redirectPcIN = tgt;
      imemReqReady = req_rdy;
      if (q_addr.size() > 0 && (mem_mode == 0 || (mem_mode == 2 && $urandom_range(1, 0) == 1))) begin
         imemRespValid = 1'b1;
         imemRespData = memf(q_addr[0]);
      end else begin
         imemRespValid = 1'b0;
         imemRespData = $urandom;
      end
      #2;
      s_valid = validOUT;
      s_reqvalid = imemReqValid;
      s_reqaddr = imemReqAddr;
      s_pc = pcOUT;
      s_pc4 = pcPlus4OUT;
      s_req = imemReqValid && imemReqReady;
      s_deq = validOUT && readyIN;
      s_resp = imemRespValid;
      if (redir) begin
         chk("req_in_redirect", 32'(imemReqValid), 32'(0));
         chk("valid_in_redirect", 32'(validOUT), 32'(0));
      end
      if (imemReqValid) chk("req_addr", imemReqAddr, exp_fetch);
      if (s_deq) begin
         chk("out_pc", pcOUT, exp_out);
         chk("out_pc4", pcPlus4OUT, exp_out + 32'd4);
         chk("out_instr", instructionOUT, memf(exp_out));
      end
      if (w2_validOUT && readyIN) begin
         d2_pc.push_back(w2_pc);
         d2_pc4.push_back(w2_pc4);
      end
      @(posedge clk);
      #1;
      if (s_resp) void'(q_addr.pop_front());
      if (s_req) q_addr.push_back(s_reqaddr);
      if (redir) begin
         exp_fetch = {tgt[31:2], 2'b00};
         exp_out = {tgt[31:2], 2'b00};
      end else begin
         if (s_req) exp_fetch = exp_fetch + 32'd4;
         if (s_deq) begin
            exp_out = exp_out + 32'd4;
            deq_count++;
         end
      end
   endtask

   initial begin
      int n, first_seen;
      logic [31:0] first_pc;

      // Test 1: streaming from reset with 1-cycle memory
      mem_mode = 0;
      do_reset();
      chk("reset_valid", 32'(validOUT), 32'(0));
      chk("reset_pc", pcOUT, 32'h0);
      step(1, 0, 0, 1);
      chk("t1_valid_c0", 32'(s_valid), 32'(0));
      chk("t1_req_c0", 32'(s_reqvalid), 32'(1));
      step(1, 0, 0, 1);
      chk("t1_valid_c1", 32'(s_valid), 32'(0));
      step(1, 0, 0, 1);
      chk("t1_valid_c2", 32'(s_valid), 32'(1));
      chk("t1_pc_c2", s_pc, 32'h0);
      chk("t1_pc4_c2", s_pc4, 32'h4);
      for (int i = 0; i < 8; i++) begin
         step(1, 0, 0, 1);
         chk("t1_stream", 32'(s_valid), 32'(1));
      end

      // Test 5 rides on the second instance during test 1
      chk("t5_count", 32'(d2_pc.size() >= 3), 32'(1));
      chk("t5_pc0", d2_pc[0], 32'hFFFF_FFF8);
      chk("t5_pc1", d2_pc[1], 32'hFFFF_FFFC);
      chk("t5_pc1_plus4", d2_pc4[1], 32'h0);
      chk("t5_pc2", d2_pc[2], 32'h0);

      // Test 2: downstream stall fills the buffer
      do_reset();
      n = 0;
      for (int i = 0; i < 6; i++) begin
         step(0, 0, 0, 1);
         if (s_req) n++;
         if (i >= 2) chk("t2_hold_pc", s_pc, 32'h0);
      end
      chk("t2_accepts", 32'(n), 32'(4));
      chk("t2_reqvalid_low", 32'(s_reqvalid), 32'(0));
      n = deq_count;
      for (int i = 0; i < 4; i++) step(1, 0, 0, 1);
      chk("t2_drain", 32'(deq_count - n), 32'(4));

      // Test 3: redirect with two requests outstanding
      do_reset();
      mem_mode = 1;
      step(1, 0, 0, 1);
      step(1, 0, 0, 1);
      chk("t3_outstanding", 32'(q_addr.size()), 32'(2));
      step(1, 1, 32'h0000_0103, 1);
      mem_mode = 0;
      step(1, 0, 0, 1);
      chk("t3_new_req_valid", 32'(s_reqvalid), 32'(1));
      chk("t3_new_req_addr", s_reqaddr, 32'h0000_0100);
      first_seen = 0;
      first_pc = '0;
      for (int i = 0; i < 10; i++) begin
         step(1, 0, 0, 1);
         if (s_valid && first_seen == 0) begin
            first_seen = 1;
            first_pc = s_pc;
         end
      end
      chk("t3_first_seen", 32'(first_seen), 32'(1));
      chk("t3_first_pc", first_pc, 32'h0000_0100);

      // Test 4: redirect with a response in flight, then redirect again
      do_reset();
      for (int i = 0; i < 5; i++) step(1, 0, 0, 1);
      step(1, 1, 32'h0000_2000, 1);
      step(1, 1, 32'h0000_3000, 1);
      first_seen = 0;
      first_pc = '0;
      for (int i = 0; i < 12; i++) begin
         step(1, 0, 0, 1);
         if (s_valid && first_seen == 0) begin
            first_seen = 1;
            first_pc = s_pc;
         end
      end
      chk("t4_first_seen", 32'(first_seen), 32'(1));
      chk("t4_first_pc", first_pc, 32'h0000_3000);
      // With no stale credits left, a stall fills all four entries
      for (int i = 0; i < 8; i++) step(0, 0, 0, 1);
      mem_mode = 1;
      n = deq_count;
      for (int i = 0; i < 8; i++) step(1, 0, 0, 1);
      chk("t4_full_credit", 32'(deq_count - n), 32'(4));
      mem_mode = 0;
      for (int i = 0; i < 6; i++) step(1, 0, 0, 1);

      // Test 6: asynchronous reset with live and outstanding entries
      do_reset();
      step(1, 1, 32'h0000_0040, 1);
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      mem_mode = 1;
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
      chk("t6_pre_valid", 32'(validOUT), 32'(1));
      chk("t6_pre_pc", pcOUT, 32'h0000_0040);
      imemRespValid = 1'b0;
      reset = 1'b0;
      #1;
      chk("t6_valid_clr", 32'(validOUT), 32'(0));
      chk("t6_req_clr", 32'(imemReqValid), 32'(0));
      chk("t6_pc_clr", pcOUT, 32'h0);
      chk("t6_pc4_clr", pcPlus4OUT, 32'h0);
      chk("t6_instr_clr", instructionOUT, 32'h0);
      mem_mode = 0;
      do_reset();
      n = deq_count;
      for (int i = 0; i < 6; i++) step(1, 0, 0, 1);
      chk("t6_restart", 32'(deq_count - n), 32'(4));

      // Randomized traffic against the reference model
      mem_mode = 2;
      do_reset();
      n = deq_count;
      for (int i = 0; i < 2000; i++) begin
         step($urandom_range(3, 0) != 0, $urandom_range(31, 0) == 0, $urandom,
              $urandom_range(3, 0) != 0);
      end
      chk("rand_progress", 32'(deq_count - n > 200), 32'(1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
